display_controller: RTL

//  Drives the board's 7-segment digits from a binary value written by the processor.

---
 rtl/display_controller_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/display_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/display_controller_pkg.sv
// Shared definitions for the 7-segment display controller:
// converter FSM encoding, segment constants and a parameter sanity helper.
package display_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Active-low segments {a..g}: all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

    // True when DIGITS decimal digits can hold the largest DATA_W-bit value.
    function automatic bit digits_fit(input int digits, input int data_w);
        longint unsigned pow10;
        pow10 = 64'd1;
        for (int k = 0; k < digits; k++) begin
            pow10 = pow10 * 64'd10;
        end
        return pow10 > ((64'd1 << data_w) - 64'd1);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD nibble to active-low 7-segment code {a..g}; non-decimal codes blank.
module seg7_decode
    import display_controller_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup table, no state.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b0000001;
            4'd1: seg = 7'b1001111;
            4'd2: seg = 7'b0010010;
            4'd3: seg = 7'b0000110;
            4'd4: seg = 7'b1001100;
            4'd5: seg = 7'b0100100;
            4'd6: seg = 7'b0100000;
            4'd7: seg = 7'b0001111;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0001100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_controller.sv
// Binary-to-decimal display driver: captures a value, converts it to BCD with
// shift-and-add-3 (one bit per clock), then commits BCD and segment codes
// together so the display never shows a half-converted number.
module display_controller
    import display_controller_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DIGITS      = 5,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  Carregar,
    input  logic [DATA_W-1:0]     Valor,
    output logic                  Ocupado,
    output logic [4*DIGITS-1:0]   Digitos,
    output logic [7*DIGITS-1:0]   Saida
);

    localparam int SR_W  = 4*DIGITS + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    if (!digits_fit(DIGITS, DATA_W)) begin : g_bad_digits
        $error("display_controller: DIGITS too small for DATA_W");
    end

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [SR_W-1:0]      sr_reg;
    logic [SR_W-1:0]      sr_adj;
    logic [4*DIGITS-1:0]  bcd;
    logic [7*DIGITS-1:0]  seg_raw;
    logic [7*DIGITS-1:0]  seg_shown;
    logic [7*DIGITS-1:0]  seg_reset;
    logic [DIGITS:1]      upper_zero;

    // The BCD field occupies the top of the shift register.
    assign bcd = sr_reg[SR_W-1 -: 4*DIGITS];

    // The binary part only shifts; it never gets the add-3 correction.
    assign sr_adj[DATA_W-1:0] = sr_reg[DATA_W-1:0];

    // Nothing above the top digit, so it is blankable purely on its own value.
    assign upper_zero[DIGITS] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            // Add 3 to any nibble >= 5 so the following shift carries correctly.
            assign sr_adj[DATA_W + 4*gi +: 4] =
                (bcd[4*gi +: 4] >= 4'd5) ? bcd[4*gi +: 4] + 4'd3 : bcd[4*gi +: 4];

            seg7_decode u_dec (
                .bcd (bcd[4*gi +: 4]),
                .seg (seg_raw[7*gi +: 7])
            );

            if (gi == 0) begin : g_units
                // Units digit is always lit so a zero value still shows "0".
                assign seg_shown[6:0] = seg_raw[6:0];
                assign seg_reset[6:0] = SEG_ZERO;
            end else begin : g_upper
                if (gi < DIGITS - 1) begin : g_chain
                    assign upper_zero[gi] = (bcd[4*gi +: 4] == 4'd0) && upper_zero[gi+1];
                end else begin : g_top
                    assign upper_zero[gi] = (bcd[4*gi +: 4] == 4'd0);
                end
                assign seg_shown[7*gi +: 7] = (BLANK_ZEROS && upper_zero[gi]) ?
                                              SEG_BLANK : seg_raw[7*gi +: 7];
                assign seg_reset[7*gi +: 7] = BLANK_ZEROS ? SEG_BLANK : SEG_ZERO;
            end
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: the last shift is the one taken with cnt_reg = DATA_W-1.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (Carregar) state_next = ST_CONV;
            ST_CONV:   if (cnt_reg == CNT_W'(DATA_W - 1)) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: busy from the accepting edge until the commit edge.
    always_comb begin
        Ocupado = (state_reg != ST_IDLE);
    end

    // Conversion datapath: load, then adjust-and-shift once per clock.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sr_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (Carregar) begin
                        sr_reg  <= {{(4*DIGITS){1'b0}}, Valor};
                        cnt_reg <= '0;
                    end
                end
                ST_CONV: begin
                    sr_reg  <= sr_adj << 1;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Output registers: updated only on the commit edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            Digitos <= '0;
            Saida   <= seg_reset;
        end else if (state_reg == ST_COMMIT) begin
            Digitos <= bcd;
            Saida   <= seg_shown;
        end
    end

endmodule
